deco_sched: RTL and testbench
=============================

# deco_sched

Frame scheduler that shares one `Deco` turbo-decoder instance between two requesters. It round-robin arbitrates 84-bit coded frames, serialises each into the decoder's 4-beat, 21-bit `start_i`/`data_i` load protocol, waits for `done_o`, and returns the 5-bit decoded result tagged with the requester ID. A timeout watchdog resets a hung decoder and returns an error response, so a requester never stalls indefinitely.

## Interface
- `BEAT_W`, 21: decoder input beat width.
- `NBEAT`, 4: beats per frame; `FRAME_W = BEAT_W*NBEAT` = 84.
- `OUT_W`, 5: decoder result width.
- `TIMEOUT`, 1023: maximum WAIT cycles before the watchdog fires.
- `TO_W`, 10: timeout counter width.

- `clk_p_i` in 1: single clock, rising edge.
- `reset_p_i` in 1: reset, synchronous, active-high.
- `req_valid_i` in 2: per-requester frame valid.
- `req_frame_i` in 2*84: frames; requester r occupies `[r*84 +: 84]`, beat k is bits `[k*21 +: 21]`.
- `req_ready_o` out 2: one-hot accept; a frame transfers when valid&ready.
- `rsp_valid_o` out 1: result valid.
- `rsp_data_o` out 5: decoded bits; 0 on error.
- `rsp_id_o` out 1: requester that owns the result.
- `rsp_err_o` out 1: result came from a timeout.
- `rsp_ready_i` in 1: result consumer ready.
- `deco_rst_n_o` out 1: decoder reset, active-low.
- `deco_start_o` out 1: to `Deco.start_i`.
- `deco_data_o` out 21: to `Deco.data_i`.
- `deco_done_i` in 1: from `Deco.done_o`.
- `deco_data_i` in 5: from `Deco.data_o`.
- `busy_o` out 1: FSM not in IDLE.
- `frame_cnt_o` out 16: count of completed responses, error responses included; wraps at 65535→0.

## Operation
- **FSM states:** IDLE, LOAD, HOLD, WAIT, FLUSH, RESP.
- **IDLE**
  - If any `req_valid_i` is set, the arbiter grants one requester.
  - `req_ready_o[g]` = 1 combinationally in the same cycle.
  - The frame is latched into an 84-bit register and the ID is latched.
  - Next state: LOAD, beat counter = 0.
- **Arbitration:** round-robin. Priority goes to the requester not granted last. After reset, requester 0 has priority.
- **LOAD**
  - `deco_start_o` = 1, `deco_data_o` = beat[cnt], cnt increments each cycle.
  - After beat 3, go to HOLD.
- **HOLD**
  - `deco_start_o` = 1 for exactly one cycle; `deco_data_o` holds beat 3.
  - Then go to WAIT and clear the timeout counter.
- **WAIT**
  - `deco_start_o` = 0; `deco_data_o` holds beat 3; the timeout counter increments.
  - If `deco_done_i` = 1: capture `deco_data_i`, set err = 0, go to RESP.
  - Else if counter == `TIMEOUT`-1: go to FLUSH.
- **FLUSH**
  - `deco_rst_n_o` = 0 for 2 cycles.
  - Then go to RESP with data = 0, err = 1.
- **RESP**
  - `rsp_valid_o` = 1 and is held stable until `rsp_ready_i`.
  - On the handshake: increment `frame_cnt_o`, update the round-robin pointer, go to IDLE.
- `deco_done_i` outside WAIT is ignored.
- `req_ready_o` is 0 in every state except IDLE.

## Timing
- **Reset:** while `reset_p_i` = 1, evaluated at the clock edge:
  - State is IDLE.
  - All outputs are 0 (`req_ready_o`, `rsp_*`, `deco_start_o`, `deco_data_o`, `busy_o`, `frame_cnt_o`), except `deco_rst_n_o` = 0.
  - `deco_rst_n_o` = `~reset_p_i` OR-combined with FLUSH, so the decoder is held in reset together with the scheduler.
- **Reset mid-operation:** any in-flight frame or pending response is dropped, and the round-robin pointer returns to requester 0.
- **Accept at edge T:**
  - `deco_start_o` is high during cycles T+1..T+5: beats 0..3 at T+1..T+4, hold at T+5.
  - WAIT begins at T+6.
- **Done:** `deco_done_i` sampled at edge D gives `rsp_valid_o` = 1 from D+1.
- **Throughput:** the RESP handshake at edge R returns to IDLE at R+1. The next frame can be accepted at R+1, so the best-case interval is 7 cycles plus decoder latency.
- **Done and timeout on the same cycle:** done wins; err = 0.
- **Timeout response:** `rsp_valid_o` rises `TIMEOUT`+2 cycles after WAIT entry.
- **Both requesters valid:** only one `req_ready_o` bit is ever set. A continuously valid requester is served at most every other frame while the other is also valid.
- All outputs are registered, except `req_ready_o` (a combinational function of state, `req_valid_i` and the pointer) and `deco_rst_n_o`.

## Structure
- **`deco_pkg`:** `BEAT_W`, `NBEAT`, `FRAME_W`, `OUT_W`, and the typedef `sched_state_t` for the FSM states.
- **`deco_rr_arb`:** one sub-module, a 2-input round-robin arbiter.
  - Inputs: `req`, `advance`.
  - Outputs: one-hot `grant`, `grant_id`.
  - Contains the pointer register, which is reset to favour requester 0.
- **Remaining logic:** the FSM, beat counter, frame register, timeout counter, and response register live in `deco_sched`.

## Test plan
- **Single frame:** requester 0 sends frame 84'h0_F2CF_1234_5678_9ABC_DEF0 and a model decoder raises done with 5'b10110 after 8 WAIT cycles.
  - Beats appear in order, bits [20:0] first.
  - `deco_start_o` is high for 5 cycles.
  - `rsp_data_o` = 10110, `rsp_id_o` = 0, `rsp_err_o` = 0.
- **Contention:** both requesters hold valid for 4 frames.
  - Grants alternate 0,1,0,1.
  - `rsp_id_o` sequence matches.
  - `frame_cnt_o` = 4.
- **Timeout:** with `TIMEOUT` = 16, the decoder never raises done.
  - `deco_rst_n_o` is low for 2 cycles.
  - Then `rsp_valid_o` with data 0, err 1.
  - The next frame is processed normally.
- **Back-pressure:** `rsp_ready_i` is held 0 for 10 cycles.
  - `rsp_*` stays stable.
  - `req_ready_o` stays 0.
  - A spurious `deco_done_i` during RESP is ignored.
- **Reset mid-WAIT:** `reset_p_i` is asserted for 1 cycle during WAIT.
  - All outputs return to reset values and no response is issued.
  - The next accept goes to requester 0 when both requesters are valid.
- **Done/timeout collision:** `deco_done_i` arrives on the final timeout cycle.
  - The result is captured with err = 0.
  - `deco_rst_n_o` never drops.

Source files
------------

// File: rtl/deco_pkg.sv
// Shared types and widths for the Deco frame scheduler.
package deco_pkg;
  localparam int BEAT_W  = 21;
  localparam int NBEAT   = 4;
  localparam int FRAME_W = BEAT_W * NBEAT;
  localparam int OUT_W   = 5;
  localparam int CNT_W   = $clog2(NBEAT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HOLD, S_WAIT, S_FLUSH, S_RESP
  } sched_state_t;

  function automatic logic [BEAT_W-1:0] beat_of(input logic [FRAME_W-1:0] f,
                                                input logic [CNT_W-1:0]   idx);
    return f[int'(idx)*BEAT_W +: BEAT_W];
  endfunction
endpackage

// File: rtl/deco_rr_arb.sv
// Two-input round-robin arbiter; priority goes to the requester not granted last.
module deco_rr_arb (
  input  logic       clk_p_i,
  input  logic       reset_p_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);
  logic r_ptr;

  always_comb begin
    grant_id = req[r_ptr] ? r_ptr : ~r_ptr;
    grant    = 2'b00;
    if (|req) grant[grant_id] = 1'b1;
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i)    r_ptr <= 1'b0;
    else if (advance) r_ptr <= ~grant_id;
  end
endmodule

// File: rtl/deco_sched.sv
// Shares one Deco turbo decoder between two requesters: arbitrate, serialise
// the 4-beat load, wait for done (with watchdog flush), and return a tagged result.
module deco_sched
  import deco_pkg::*;
#(
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                 clk_p_i,
  input  logic                 reset_p_i,
  input  logic [1:0]           req_valid_i,
  input  logic [2*FRAME_W-1:0] req_frame_i,
  output logic [1:0]           req_ready_o,
  output logic                 rsp_valid_o,
  output logic [OUT_W-1:0]     rsp_data_o,
  output logic                 rsp_id_o,
  output logic                 rsp_err_o,
  input  logic                 rsp_ready_i,
  output logic                 deco_rst_n_o,
  output logic                 deco_start_o,
  output logic [BEAT_W-1:0]    deco_data_o,
  input  logic                 deco_done_i,
  input  logic [OUT_W-1:0]     deco_data_i,
  output logic                 busy_o,
  output logic [15:0]          frame_cnt_o
);
  sched_state_t       r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx, w_cnt_inc;
  logic [TO_W-1:0]    r_to, w_to_nx;
  logic [FRAME_W-1:0] r_frame, w_frame_nx, w_sel_frame;
  logic               r_id, w_id_nx;
  logic               r_start, w_start_nx;
  logic [BEAT_W-1:0]  r_data, w_data_nx;
  logic               r_rsp_valid, w_rsp_valid_nx;
  logic [OUT_W-1:0]   r_rsp_data, w_rsp_data_nx;
  logic               r_rsp_id, w_rsp_id_nx;
  logic               r_rsp_err, w_rsp_err_nx;
  logic [15:0]        r_frame_cnt, w_frame_cnt_nx;
  logic               r_busy;
  logic [1:0]         w_arb_req, w_grant;
  logic               w_grant_id, w_adv, w_accept;

  // Outside IDLE the arbiter sees only the owner's request, so the advance
  // at the response handshake moves the pointer past the requester just served.
  assign w_arb_req = (r_state == S_IDLE) ? req_valid_i : (r_id ? 2'b10 : 2'b01);

  deco_rr_arb u_arb (
    .clk_p_i   (clk_p_i),
    .reset_p_i (reset_p_i),
    .req       (w_arb_req),
    .advance   (w_adv),
    .grant     (w_grant),
    .grant_id  (w_grant_id)
  );

  assign req_ready_o = (r_state == S_IDLE && !reset_p_i) ? w_grant : 2'b00;
  assign w_accept    = |req_ready_o;
  assign w_sel_frame = w_grant_id ? req_frame_i[FRAME_W +: FRAME_W] : req_frame_i[0 +: FRAME_W];
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_to_nx        = r_to;
    w_frame_nx     = r_frame;
    w_id_nx        = r_id;
    w_start_nx     = 1'b0;
    w_data_nx      = r_data;
    w_rsp_valid_nx = r_rsp_valid;
    w_rsp_data_nx  = r_rsp_data;
    w_rsp_id_nx    = r_rsp_id;
    w_rsp_err_nx   = r_rsp_err;
    w_frame_cnt_nx = r_frame_cnt;
    w_adv          = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
        w_state_nx = S_LOAD;
        w_cnt_nx   = '0;
        w_frame_nx = w_sel_frame;
        w_id_nx    = w_grant_id;
        w_start_nx = 1'b1;
        w_data_nx  = beat_of(w_sel_frame, '0);
      end
      S_LOAD: begin
        w_start_nx = 1'b1;
        if (r_cnt == CNT_W'(NBEAT-1)) begin
          w_state_nx = S_HOLD;
        end else begin
          w_cnt_nx  = w_cnt_inc;
          w_data_nx = beat_of(r_frame, w_cnt_inc);
        end
      end
      S_HOLD: begin
        w_state_nx = S_WAIT;
        w_to_nx    = '0;
      end
      S_WAIT: begin
        w_to_nx = r_to + TO_W'(1);
        if (deco_done_i) begin
          w_state_nx     = S_RESP;
          w_rsp_valid_nx = 1'b1;
          w_rsp_data_nx  = deco_data_i;
          w_rsp_id_nx    = r_id;
          w_rsp_err_nx   = 1'b0;
        end else if (r_to == TO_W'(TIMEOUT-1)) begin
          w_state_nx = S_FLUSH;
          w_cnt_nx   = '0;
        end
      end
      S_FLUSH: begin
        if (r_cnt == CNT_W'(1)) begin
          w_state_nx     = S_RESP;
          w_rsp_valid_nx = 1'b1;
          w_rsp_data_nx  = '0;
          w_rsp_id_nx    = r_id;
          w_rsp_err_nx   = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      S_RESP: if (rsp_ready_i) begin
        w_state_nx     = S_IDLE;
        w_rsp_valid_nx = 1'b0;
        w_frame_cnt_nx = r_frame_cnt + 16'd1;
        w_adv          = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) r_state <= S_IDLE;
    else           r_state <= w_state_nx;
  end

  always_ff @(posedge clk_p_i) begin
    if (reset_p_i) begin
      r_cnt       <= '0;
      r_to        <= '0;
      r_frame     <= '0;
      r_id        <= 1'b0;
      r_start     <= 1'b0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nx;
      r_to        <= w_to_nx;
      r_frame     <= w_frame_nx;
      r_id        <= w_id_nx;
      r_start     <= w_start_nx;
      r_data      <= w_data_nx;
      r_rsp_valid <= w_rsp_valid_nx;
      r_rsp_data  <= w_rsp_data_nx;
      r_rsp_id    <= w_rsp_id_nx;
      r_rsp_err   <= w_rsp_err_nx;
      r_frame_cnt <= w_frame_cnt_nx;
      r_busy      <= (w_state_nx != S_IDLE);
    end
  end

  assign deco_rst_n_o = ~(reset_p_i | (r_state == S_FLUSH));
  assign deco_start_o = r_start;
  assign deco_data_o  = r_data;
  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_data_o   = r_rsp_data;
  assign rsp_id_o     = r_rsp_id;
  assign rsp_err_o    = r_rsp_err;
  assign busy_o       = r_busy;
  assign frame_cnt_o  = r_frame_cnt;
endmodule

// File: tb/tb_deco_sched.sv
// Randomised bench for deco_sched with a behavioural decoder and scheduler model.
module tb_deco_sched;
  import deco_pkg::*;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, rsp_ready, done;
  logic [1:0]           req_valid, req_ready;
  logic [2*FRAME_W-1:0] req_frame;
  logic                 rsp_valid, rsp_id, rsp_err, deco_rst_n, deco_start, busy;
  logic [OUT_W-1:0]     rsp_data, dec_res;
  logic [BEAT_W-1:0]    deco_data;
  logic [15:0]          frame_cnt;

  deco_sched #(.TIMEOUT(TO), .TO_W(10)) dut (
    .clk_p_i(clk), .reset_p_i(rst), .req_valid_i(req_valid), .req_frame_i(req_frame),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_id_o(rsp_id), .rsp_err_o(rsp_err), .rsp_ready_i(rsp_ready),
    .deco_rst_n_o(deco_rst_n), .deco_start_o(deco_start), .deco_data_o(deco_data),
    .deco_done_i(done), .deco_data_i(dec_res), .busy_o(busy), .frame_cnt_o(frame_cnt)
  );

  int n_checks = 0, n_err = 0;
  int pref = 0, exp_cnt = 0;   // model: preferred requester, completed responses

  logic [1:0]        ob_grant;
  int                ob_acc_wait, ob_nstart, ob_rstlow, ob_rsp_k, ob_bp_bad, ob_rdy_bad;
  bit                ob_to;
  logic [BEAT_W-1:0] ob_beats [0:7];
  logic [OUT_W-1:0]  ob_data;
  logic              ob_id, ob_err;

  function automatic logic [FRAME_W-1:0] rnd_frame();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[FRAME_W-1:0];
  endfunction

  // Drives one frame end to end and records what the DUT did; cycle k counts from the accept edge.
  task automatic do_frame(input logic [1:0] v, input logic [FRAME_W-1:0] f0, f1,
                          input int done_after, input logic [OUT_W-1:0] dres,
                          input int bp, input bit keep);
    bit got;
    ob_to = 0; ob_nstart = 0; ob_rstlow = 0; ob_rsp_k = -1; ob_bp_bad = 0;
    ob_rdy_bad = 0; ob_grant = 2'b00; ob_acc_wait = -1; got = 0;
    req_frame = {f1, f0}; req_valid = v;
    for (int w = 0; w < 8; w++) begin
      if (w > 0) @(negedge clk);
      #1;
      if (|req_ready) begin ob_grant = req_ready; ob_acc_wait = w; break; end
    end
    if (ob_acc_wait < 0) begin ob_to = 1; req_valid = 2'b00; return; end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (req_ready !== 2'b00) ob_rdy_bad++;
      if (deco_start === 1'b1) begin
        if (ob_nstart < 8) ob_beats[ob_nstart] = deco_data;
        ob_nstart++;
      end
      if (deco_rst_n !== 1'b1) ob_rstlow++;
      if (rsp_valid === 1'b1) begin ob_rsp_k = k; got = 1; break; end
      if (!keep) req_valid = 2'b00;
      done    = (done_after >= 0 && k == 6 + done_after);
      dec_res = done ? dres : OUT_W'($urandom);
    end
    done = 1'b0;
    if (!keep) req_valid = 2'b00;
    if (!got) begin ob_to = 1; return; end
    ob_data = rsp_data; ob_id = rsp_id; ob_err = rsp_err;
    for (int b = 0; b < bp; b++) begin
      done = 1'b1; dec_res = ~ob_data;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== ob_data || rsp_id !== ob_id ||
          rsp_err !== ob_err || req_ready !== 2'b00 || busy !== 1'b1) ob_bp_bad++;
    end
    done = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0) ob_bp_bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; req_frame = {rnd_frame(), rnd_frame()};
    done = 1'b1; dec_res = 5'h1f; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL rst_req_ready: got %b exp 00", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_data !== '0) begin n_err++; $display("FAIL rst_rsp_data: got %h exp 0", rsp_data); end
    n_checks++; if ({rsp_id, rsp_err} !== 2'b00) begin n_err++; $display("FAIL rst_rsp_id_err: got %b exp 00", {rsp_id, rsp_err}); end
    n_checks++; if (deco_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b exp 0", deco_start); end
    n_checks++; if (deco_data !== '0) begin n_err++; $display("FAIL rst_deco_data: got %h exp 0", deco_data); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_checks++; if (frame_cnt !== 16'd0) begin n_err++; $display("FAIL rst_frame_cnt: got %0d exp 0", frame_cnt); end
    n_checks++; if (deco_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_deco_rst_n: got %b exp 0", deco_rst_n); end
    rst = 1'b0; req_valid = 2'b00; done = 1'b0; rsp_ready = 1'b0;
    pref = 0; exp_cnt = 0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [FRAME_W-1:0] f;
    int bad;
    f = 84'h0_F2CF_1234_5678_9ABC_DEF0;
    do_frame(2'b01, f, rnd_frame(), 8, 5'b10110, 0, 0);
    n_checks++; if (ob_to) begin n_err++; $display("FAIL single_progress: got stall exp response"); end
    n_checks++; if (ob_grant !== 2'b01) begin n_err++; $display("FAIL single_grant: got %b exp 01", ob_grant); end
    n_checks++; if (ob_nstart != 5) begin n_err++; $display("FAIL single_start_len: got %0d exp 5", ob_nstart); end
    bad = 0;
    for (int i = 0; i < 5; i++) if (ob_beats[i] !== f[(i < 3 ? i : 3)*BEAT_W +: BEAT_W]) bad++;
    n_checks++; if (bad != 0) begin n_err++; $display("FAIL single_beats: got %0d wrong beats exp 0", bad); end
    n_checks++; if (ob_rsp_k != 15) begin n_err++; $display("FAIL single_latency: got cycle %0d exp 15", ob_rsp_k); end
    n_checks++; if ({ob_data, ob_id, ob_err} !== {5'b10110, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL single_rsp: got data %b id %b err %b exp 10110 0 0", ob_data, ob_id, ob_err); end
    n_checks++; if (ob_rstlow != 0) begin n_err++; $display("FAIL single_rst_n: got %0d low cycles exp 0", ob_rstlow); end
    pref = 1; exp_cnt++;
    n_checks++; if (frame_cnt !== exp_cnt[15:0]) begin n_err++; $display("FAIL single_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_contention();
    logic [FRAME_W-1:0] f0, f1, ef;
    logic [OUT_W-1:0]   r;
    int eid, da, bad;
    for (int n = 0; n < 4; n++) begin
      f0 = rnd_frame(); f1 = rnd_frame(); da = $urandom_range(0, 12); r = OUT_W'($urandom);
      eid = pref;
      do_frame(2'b11, f0, f1, da, r, 0, 1);
      ef = (eid != 0) ? f1 : f0;
      n_checks++; if (ob_grant !== ((eid != 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL cont_grant[%0d]: got %b exp id %0d", n, ob_grant, eid); end
      n_checks++; if (ob_id !== eid[0] || ob_data !== r || ob_err !== 1'b0) begin
        n_err++; $display("FAIL cont_rsp[%0d]: got id %b data %h err %b exp %0d %h 0", n, ob_id, ob_data, ob_err, eid, r); end
      bad = 0;
      for (int i = 0; i < 5; i++) if (ob_beats[i] !== ef[(i < 3 ? i : 3)*BEAT_W +: BEAT_W]) bad++;
      n_checks++; if (bad != 0 || ob_nstart != 5) begin
        n_err++; $display("FAIL cont_beats[%0d]: got %0d wrong of %0d exp 0 of 5", n, bad, ob_nstart); end
      n_checks++; if (ob_rsp_k != 7 + da) begin n_err++; $display("FAIL cont_latency[%0d]: got %0d exp %0d", n, ob_rsp_k, 7 + da); end
      if (n > 0) begin
        n_checks++; if (ob_acc_wait != 0) begin n_err++; $display("FAIL cont_b2b[%0d]: got wait %0d exp 0", n, ob_acc_wait); end
      end
      pref = 1 - eid; exp_cnt++;
    end
    req_valid = 2'b00;
    n_checks++; if (frame_cnt !== exp_cnt[15:0]) begin n_err++; $display("FAIL cont_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_timeout();
    logic [OUT_W-1:0] r;
    do_frame(2'b10, rnd_frame(), rnd_frame(), -1, 5'h0, 0, 0);
    n_checks++; if (ob_grant !== 2'b10) begin n_err++; $display("FAIL to_grant: got %b exp 10", ob_grant); end
    n_checks++; if (ob_rstlow != 2) begin n_err++; $display("FAIL to_rst_n: got %0d low cycles exp 2", ob_rstlow); end
    n_checks++; if (ob_rsp_k != 6 + TO + 2) begin n_err++; $display("FAIL to_latency: got %0d exp %0d", ob_rsp_k, 6 + TO + 2); end
    n_checks++; if ({ob_data, ob_id, ob_err} !== {5'h0, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL to_rsp: got data %h id %b err %b exp 00 1 1", ob_data, ob_id, ob_err); end
    pref = 0; exp_cnt++;
    r = OUT_W'($urandom);
    do_frame(2'b01, rnd_frame(), rnd_frame(), 3, r, 0, 0);
    n_checks++; if ({ob_data, ob_id, ob_err} !== {r, 1'b0, 1'b0} || ob_rstlow != 0) begin
      n_err++; $display("FAIL to_next: got data %h id %b err %b rstlow %0d exp %h 0 0 0", ob_data, ob_id, ob_err, ob_rstlow, r); end
    pref = 1; exp_cnt++;
    n_checks++; if (frame_cnt !== exp_cnt[15:0]) begin n_err++; $display("FAIL to_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_backpressure();
    logic [OUT_W-1:0] r;
    r = OUT_W'($urandom);
    do_frame(2'b01, rnd_frame(), rnd_frame(), 2, r, 10, 1);
    req_valid = 2'b00;
    n_checks++; if (ob_bp_bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d bad cycles exp 0", ob_bp_bad); end
    n_checks++; if (ob_rdy_bad != 0) begin n_err++; $display("FAIL bp_ready: got %0d busy cycles with ready exp 0", ob_rdy_bad); end
    n_checks++; if (ob_data !== r || ob_err !== 1'b0) begin n_err++; $display("FAIL bp_rsp: got %h err %b exp %h 0", ob_data, ob_err, r); end
    pref = 1; exp_cnt++;
    n_checks++; if (frame_cnt !== exp_cnt[15:0]) begin n_err++; $display("FAIL bp_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_collision();
    logic [OUT_W-1:0] r;
    r = OUT_W'($urandom);
    do_frame(2'b10, rnd_frame(), rnd_frame(), TO - 1, r, 0, 0);
    n_checks++; if ({ob_data, ob_id, ob_err} !== {r, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL coll_rsp: got data %h id %b err %b exp %h 1 0", ob_data, ob_id, ob_err, r); end
    n_checks++; if (ob_rstlow != 0) begin n_err++; $display("FAIL coll_rst_n: got %0d low cycles exp 0", ob_rstlow); end
    n_checks++; if (ob_rsp_k != 6 + TO) begin n_err++; $display("FAIL coll_latency: got %0d exp %0d", ob_rsp_k, 6 + TO); end
    pref = 0; exp_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [FRAME_W-1:0] f0, f1;
    logic [OUT_W-1:0]   r;
    int w, bad;
    req_frame = {rnd_frame(), rnd_frame()}; req_valid = 2'b11;
    w = 0; #1;
    while (req_ready === 2'b00 && w < 8) begin @(negedge clk); #1; w++; end
    n_checks++; if (req_ready !== ((pref != 0) ? 2'b10 : 2'b01)) begin
      n_err++; $display("FAIL rmid_grant: got %b exp id %0d", req_ready, pref); end
    @(negedge clk); req_valid = 2'b00;
    repeat (8) @(negedge clk);
    rst = 1'b1; req_valid = 2'b11;
    @(negedge clk);
    n_checks++; if ({req_ready, rsp_valid, deco_start, busy, deco_rst_n} !== 6'b0) begin
      n_err++; $display("FAIL rmid_outs: got %b exp 000000", {req_ready, rsp_valid, deco_start, busy, deco_rst_n}); end
    n_checks++; if (frame_cnt !== 16'd0 || deco_data !== '0 || rsp_data !== '0) begin
      n_err++; $display("FAIL rmid_regs: got cnt %0d data %h rsp %h exp 0", frame_cnt, deco_data, rsp_data); end
    rst = 1'b0; req_valid = 2'b00; pref = 0; exp_cnt = 0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || deco_start !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_err++; $display("FAIL rmid_quiet: got %0d active cycles exp 0", bad); end
    f0 = rnd_frame(); f1 = rnd_frame(); r = OUT_W'($urandom);
    do_frame(2'b11, f0, f1, 4, r, 0, 0);
    n_checks++; if (ob_grant !== 2'b01 || ob_id !== 1'b0 || ob_data !== r) begin
      n_err++; $display("FAIL rmid_next: got grant %b id %b data %h exp 01 0 %h", ob_grant, ob_id, ob_data, r); end
    pref = 1; exp_cnt++;
    n_checks++; if (frame_cnt !== exp_cnt[15:0]) begin n_err++; $display("FAIL rmid_cnt: got %0d exp %0d", frame_cnt, exp_cnt); end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; req_frame = '0; rsp_ready = 1'b0; done = 1'b0; dec_res = '0;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_backpressure();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
